// File: rtl/cache_data_array.sv
// cache_data_array: set-associative cache data store.
// WAYS banks of (2^INDEX_W sets x LINE_WORDS words x DATA_W bits), read in
// parallel with one-cycle registered latency, byte-enabled store writes and a
// critical-word-first line-refill engine (IDLE -> FILL -> DONE -> IDLE).
// Optional feature macro: CACHE_DATA_BYPASS_EN (write-first on a same-cycle
// read/store collision); when undefined the array behaves read-first.
module cache_data_array #(
  parameter int DATA_W     = 32,
  parameter int INDEX_W    = 6,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int WAY_W     = $clog2(WAYS),
  localparam int BE_W      = DATA_W / 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    RdEn,
  input  logic [INDEX_W-1:0]      Index,
  input  logic [OFF_W-1:0]        WordOff,
  output logic [WAYS*DATA_W-1:0]  RdData,
  output logic                    RdValid,
  input  logic                    WrEn,
  input  logic [WAY_W-1:0]        WrWay,
  input  logic [BE_W-1:0]         WrByteEn,
  input  logic [DATA_W-1:0]       WrData,
  input  logic                    RefillStart,
  input  logic [INDEX_W-1:0]      RefillIndex,
  input  logic [WAY_W-1:0]        RefillWay,
  input  logic [OFF_W-1:0]        RefillOff,
  input  logic                    RefillValid,
  input  logic [DATA_W-1:0]       RefillData,
  output logic                    RefillReady,
  output logic                    RefillDone,
  output logic                    Busy
);

  localparam int ADDR_W = INDEX_W + OFF_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t               state_reg;
  logic [OFF_W-1:0]     cnt_reg;
  logic [INDEX_W-1:0]   fill_index_reg;
  logic [WAY_W-1:0]     fill_way_reg;
  logic [OFF_W-1:0]     fill_off_reg;
  logic                 ready_reg;
  logic                 done_reg;
  logic                 busy_reg;
  logic                 rd_valid_reg;

  logic                 rd_fire;
  logic                 st_fire;
  logic                 fill_fire;
  logic [OFF_W-1:0]     fill_word_off;
  logic [ADDR_W-1:0]    rd_addr;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;

  // Reads and stores share Index/WordOff; both are dropped while a refill owns the array.
  assign rd_fire       = RdEn && !busy_reg;
  assign st_fire       = WrEn && !busy_reg;
  assign fill_fire     = (state_reg == ST_FILL) && RefillValid;
  // Offset wraps naturally in OFF_W bits, giving the critical-word-first order.
  assign fill_word_off = fill_off_reg + cnt_reg;
  assign rd_addr       = {Index, WordOff};
  // Stores and refill writes are mutually exclusive (Busy gates stores).
  assign wr_addr       = fill_fire ? {fill_index_reg, fill_word_off} : {Index, WordOff};
  assign wr_data       = fill_fire ? RefillData : WrData;

  // Refill sequencer with registered handshake/status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      fill_index_reg <= '0;
      fill_way_reg   <= '0;
      fill_off_reg   <= '0;
      ready_reg      <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          if (RefillStart) begin
            fill_index_reg <= RefillIndex;
            fill_way_reg   <= RefillWay;
            fill_off_reg   <= RefillOff;
            cnt_reg        <= '0;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (RefillValid) begin
            cnt_reg <= cnt_reg + OFF_W'(1);
            if (cnt_reg == OFF_W'(LINE_WORDS - 1)) begin
              ready_reg <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          ready_reg <= 1'b0;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-valid flag tracks accepted read requests one cycle later.
  always_ff @(posedge Clk) begin
    if (Rst) rd_valid_reg <= 1'b0;
    else     rd_valid_reg <= rd_fire;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [DATA_W-1:0] mem [DEPTH];
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] rd_raw_reg;
      logic [DATA_W-1:0] rd_word;

      assign we = (st_fire && (WrWay == WAY_W'(gi))) ||
                  (fill_fire && (fill_way_reg == WAY_W'(gi)));
      assign be = fill_fire ? '1 : WrByteEn;

      // Byte-lane write port; storage itself is never reset.
      always_ff @(posedge Clk) begin
        if (we) begin
          for (int b = 0; b < BE_W; b++) begin
            if (be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end

      // Registered read port; holds its value between accepted reads.
      always_ff @(posedge Clk) begin
        if (Rst)          rd_raw_reg <= '0;
        else if (rd_fire) rd_raw_reg <= mem[rd_addr];
      end

`ifdef CACHE_DATA_BYPASS_EN
      logic              byp_reg;
      logic [BE_W-1:0]   byp_be_reg;
      logic [DATA_W-1:0] byp_data_reg;

      // Capture a colliding store so its bytes can be merged over the old word.
      always_ff @(posedge Clk) begin
        if (Rst) begin
          byp_reg      <= 1'b0;
          byp_be_reg   <= '0;
          byp_data_reg <= '0;
        end else if (rd_fire) begin
          byp_reg      <= st_fire && (WrWay == WAY_W'(gi));
          byp_be_reg   <= WrByteEn;
          byp_data_reg <= WrData;
        end
      end

      // Merge captured store bytes over the pre-write word (write-first view).
      always_comb begin
        rd_word = rd_raw_reg;
        if (byp_reg) begin
          for (int b = 0; b < BE_W; b++) begin
            if (byp_be_reg[b]) rd_word[b*8 +: 8] = byp_data_reg[b*8 +: 8];
          end
        end
      end
`else
      assign rd_word = rd_raw_reg;
`endif

      assign RdData[gi*DATA_W +: DATA_W] = rd_word;
    end
  endgenerate

  assign RdValid     = rd_valid_reg;
  assign RefillReady = ready_reg;
  assign RefillDone  = done_reg;
  assign Busy        = busy_reg;

endmodule

// File: tb/tb_cache_data_array.sv
// tb_cache_data_array: directed-vector bench for cache_data_array with
// hand-computed expected values (default parameters: 32-bit, 2 ways, 4 words).
module tb_cache_data_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [5:0]  index;
  logic [1:0]  word_off;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic        wr_way;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        refill_start;
  logic [5:0]  refill_index;
  logic        refill_way;
  logic [1:0]  refill_off;
  logic        refill_valid;
  logic [31:0] refill_data;
  logic        refill_ready;
  logic        refill_done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_base;

`ifdef CACHE_DATA_BYPASS_EN
  localparam logic [31:0] SAME_EXP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SAME_EXP = 32'h0000_0000;
`endif

  cache_data_array dut (
    .Clk         (clk),
    .Rst         (rst),
    .RdEn        (rd_en),
    .Index       (index),
    .WordOff     (word_off),
    .RdData      (rd_data),
    .RdValid     (rd_valid),
    .WrEn        (wr_en),
    .WrWay       (wr_way),
    .WrByteEn    (wr_be),
    .WrData      (wr_data),
    .RefillStart (refill_start),
    .RefillIndex (refill_index),
    .RefillWay   (refill_way),
    .RefillOff   (refill_off),
    .RefillValid (refill_valid),
    .RefillData  (refill_data),
    .RefillReady (refill_ready),
    .RefillDone  (refill_done),
    .Busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (refill_done) done_cnt++;
  endtask

  function automatic logic [31:0] way_word(input int w);
    return rd_data[w*32 +: 32];
  endfunction

  task automatic do_write(input logic w, input logic [5:0] idx, input logic [1:0] off,
                          input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_way = w; index = idx; word_off = off; wr_be = be; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] idx, input logic [1:0] off);
    rd_en = 1'b1; index = idx; word_off = off;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic fill_word(input logic [31:0] d);
    refill_valid = 1'b1; refill_data = d;
    tick();
    refill_valid = 1'b0;
  endtask

  task automatic start_refill(input logic [5:0] idx, input logic w, input logic [1:0] off);
    refill_start = 1'b1; refill_index = idx; refill_way = w; refill_off = off;
    tick();
    refill_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; index = '0; word_off = '0;
    wr_en = 1'b0; wr_way = 1'b0; wr_be = '0; wr_data = '0;
    refill_start = 1'b0; refill_index = '0; refill_way = 1'b0; refill_off = '0;
    refill_valid = 1'b0; refill_data = '0;
    repeat (2) tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ready", refill_ready, 0);
    chk("rst_done", refill_done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Basic store then read
    do_write(1'b1, 6'd3, 2'd1, 4'hF, 32'hDEAD_BEEF);
    do_read(6'd3, 2'd1);
    chk("rd_valid", rd_valid, 1);
    chk("rd_way1", way_word(1), 32'hDEAD_BEEF);
    tick();
    chk("rd_valid_idle", rd_valid, 0);
    chk("rd_hold", way_word(1), 32'hDEAD_BEEF);

    // Byte-lane merge and zero-enable no-op
    do_write(1'b0, 6'd5, 2'd2, 4'hF, 32'h1122_3344);
    do_write(1'b0, 6'd5, 2'd2, 4'h5, 32'hAABB_CCDD);
    do_read(6'd5, 2'd2);
    chk("byte_merge", way_word(0), 32'h11BB_33DD);
    do_write(1'b0, 6'd5, 2'd2, 4'h0, 32'hFFFF_FFFF);
    do_read(6'd5, 2'd2);
    chk("be_zero_noop", way_word(0), 32'h11BB_33DD);

    // Same-cycle read and store to the same word
    do_write(1'b0, 6'd7, 2'd0, 4'hF, 32'h0000_0000);
    do_write(1'b1, 6'd7, 2'd0, 4'hF, 32'h1234_5678);
    rd_en = 1'b1; wr_en = 1'b1; wr_way = 1'b0; index = 6'd7; word_off = 2'd0;
    wr_be = 4'hF; wr_data = 32'hFFFF_FFFF;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("same_cyc_way0", way_word(0), SAME_EXP);
    chk("same_cyc_way1", way_word(1), 32'h1234_5678);
    do_read(6'd7, 2'd0);
    chk("same_cyc_later", way_word(0), 32'hFFFF_FFFF);

    // Wrapping refill with one stall; reads and stores during Busy are dropped
    done_base = done_cnt;
    start_refill(6'd9, 1'b1, 2'd2);
    chk("fill_busy", busy, 1);
    chk("fill_ready", refill_ready, 1);
    rd_en = 1'b1; index = 6'd9; word_off = 2'd2;
    fill_word(32'hA000_0000);
    chk("rd_during_busy", rd_valid, 0);
    wr_en = 1'b1; wr_way = 1'b0; index = 6'd5; word_off = 2'd2; wr_be = 4'hF; wr_data = 32'h0;
    tick();
    wr_en = 1'b0;
    chk("stall_busy", busy, 1);
    fill_word(32'hA111_1111);
    fill_word(32'hA222_2222);
    fill_word(32'hA333_3333);
    rd_en = 1'b0;
    chk("done_pulse", refill_done, 1);
    chk("done_busy", busy, 1);
    chk("done_ready", refill_ready, 0);
    tick();
    chk("after_busy", busy, 0);
    chk("done_once", done_cnt - done_base, 1);
    do_read(6'd9, 2'd2); chk("wrap_off2", way_word(1), 32'hA000_0000);
    do_read(6'd9, 2'd3); chk("wrap_off3", way_word(1), 32'hA111_1111);
    do_read(6'd9, 2'd0); chk("wrap_off0", way_word(1), 32'hA222_2222);
    do_read(6'd9, 2'd1); chk("wrap_off1", way_word(1), 32'hA333_3333);
    do_read(6'd5, 2'd2); chk("store_dropped", way_word(0), 32'h11BB_33DD);

    // RefillStart during FILL is ignored
    start_refill(6'd10, 1'b0, 2'd0);
    refill_start = 1'b1; refill_index = 6'd11; refill_way = 1'b1; refill_off = 2'd3;
    fill_word(32'hB000_0000);
    refill_start = 1'b0;
    fill_word(32'hB111_1111);
    fill_word(32'hB222_2222);
    fill_word(32'hB333_3333);
    tick();
    do_read(6'd10, 2'd0); chk("ign_off0", way_word(0), 32'hB000_0000);
    do_read(6'd10, 2'd1); chk("ign_off1", way_word(0), 32'hB111_1111);
    do_read(6'd10, 2'd3); chk("ign_off3", way_word(0), 32'hB333_3333);

    // Reset mid-refill, then a fresh refill restarts the count
    done_base = done_cnt;
    start_refill(6'd12, 1'b0, 2'd1);
    fill_word(32'hC000_0000);
    fill_word(32'hC111_1111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", refill_ready, 0);
    chk("rst_mid_nodone", done_cnt - done_base, 0);
    start_refill(6'd13, 1'b0, 2'd3);
    chk("restart_busy", busy, 1);
    fill_word(32'hD000_0000);
    fill_word(32'hD111_1111);
    fill_word(32'hD222_2222);
    fill_word(32'hD333_3333);
    chk("restart_done", refill_done, 1);
    tick();
    do_read(6'd13, 2'd3); chk("restart_off3", way_word(0), 32'hD000_0000);
    do_read(6'd13, 2'd2); chk("restart_off2", way_word(0), 32'hD333_3333);
    do_read(6'd12, 2'd1); chk("partial_off1", way_word(0), 32'hC000_0000);
    do_read(6'd12, 2'd2); chk("partial_off2", way_word(0), 32'hC111_1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_data_array.md
# cache_data_array

Parametrised, set-associative cache data store: WAYS banks of (2^INDEX_W sets × LINE_WORDS words × DATA_W bits), all ways read in parallel with registered one-cycle latency. Adds byte-enabled store writes and an internal line-refill engine that takes a critical-word-first burst from the memory side and wraps around the line. Sits between the cache controller (tag compare, way select, hit/miss) and the bus interface unit that returns refill data.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- INDEX_W, 6, set index width; set count = 2^INDEX_W
- WAYS, 2, associativity; power of 2, ≥2
- LINE_WORDS, 4, words per line; power of 2, ≥2
- Derived: OFF_W = $clog2(LINE_WORDS), WAY_W = $clog2(WAYS), BE_W = DATA_W/8
- Clock/reset: one clock; reset is synchronous and active-high.

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous active-high reset
- RdEn  in  1  read request (all ways)
- Index  in  INDEX_W  set for read/write
- WordOff  in  OFF_W  word within line for read/write
- RdData  out  WAYS*DATA_W  way w at bits [w*DATA_W +: DATA_W]
- RdValid  out  1  RdData is valid for the request of the previous cycle
- WrEn  in  1  store write
- WrWay  in  WAY_W  target way of store
- WrByteEn  in  BE_W  byte lane enables
- WrData  in  DATA_W  store data
- RefillStart  in  1  begin line refill (accepted only in IDLE)
- RefillIndex  in  INDEX_W  set to refill
- RefillWay  in  WAY_W  victim way
- RefillOff  in  OFF_W  first (critical) word offset
- RefillValid  in  1  RefillData valid
- RefillData  in  DATA_W  refill word
- RefillReady  out  1  engine accepts a refill word this cycle
- RefillDone  out  1  one-cycle pulse: line complete
- Busy  out  1  refill in progress

## Operation
- Storage is not reset; contents are undefined until written.
- Read: RdEn && !Busy → next cycle RdData = all WAYS words at {Index, WordOff}, RdValid = 1. RdEn while Busy is dropped (RdValid = 0). RdData holds its value when RdValid = 0.
- Store: WrEn && !Busy → writes the byte lanes set in WrByteEn of way WrWay at {Index, WordOff}; other lanes are unchanged. WrEn while Busy is dropped. WrByteEn = 0 is a no-op.
- Refill FSM, states IDLE → FILL → DONE → IDLE:
  - IDLE: RefillStart latches index, way and offset; the counter is cleared; next state FILL. RdEn/WrEn presented in the same cycle are still serviced.
  - FILL: RefillReady = 1, Busy = 1. Each RefillValid writes a full word to the latched way/index at offset (RefillOff + count) mod LINE_WORDS, then count++. When count reaches LINE_WORDS-1 and that word is accepted, next state is DONE. Cycles with RefillValid = 0 are stalls.
  - DONE: RefillDone = 1 for one cycle, Busy = 1; next state IDLE.
  - RefillStart outside IDLE is ignored.
- Rst mid-refill: FSM → IDLE and the counter is cleared; words already written stay in the array (partial line). The controller must not mark that line valid.

## Timing
- Read latency: 1 cycle (request at edge N, data after edge N+1).
- Store: written at the edge where WrEn is sampled.
- Refill: minimum LINE_WORDS + 2 cycles from RefillStart to the end of the RefillDone pulse.
- Busy rises in the cycle after RefillStart is accepted and falls in the cycle after DONE.
- Reset values: RdData = 0, RdValid = 0, RefillReady = 0, RefillDone = 0, Busy = 0, FSM = IDLE, count = 0.

## Configuration
- CACHE_DATA_BYPASS_EN defined: write-first. RdEn and WrEn in the same cycle at the same {Index, WordOff} returns, for way WrWay, the old word merged with the enabled new bytes. Other ways return stored data.
- Not defined: read-first. The same case returns the pre-write word. The write still takes effect for later reads.

## Test plan
- Reset, then RdEn at Index=3, WordOff=1 after writing 0xDEADBEEF (WrByteEn=0xF, way 1) → next cycle RdValid=1 and way 1 slice = 0xDEADBEEF.
- Byte merge: write 0x11223344 (BE=0xF), then 0xAABBCCDD (BE=0x5), same word → reads 0x11BB33DD.
- Wrapping refill: LINE_WORDS=4, RefillOff=2, data W0..W3 with one stall cycle → offsets 2,3,0,1 hold W0,W1,W2,W3; RefillDone pulses once; Busy high throughout; RdEn during Busy gives RdValid=0.
- Same-cycle RdEn+WrEn at the same word (old 0x0, new 0xFFFFFFFF, BE=0xF) → 0xFFFFFFFF with CACHE_DATA_BYPASS_EN, 0x00000000 without.
- Rst asserted after 2 of 4 refill words → Busy=0, RefillReady=0, no RefillDone; a new RefillStart restarts with count 0; the 2 written words are readable.
- RefillStart while in FILL is ignored; the latched way/index stay unchanged (checked by readback).
